mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 27 ++
 rtl/mem_loader_if.sv | 9 +
 rtl/loader_pulse_timer.sv | 27 ++
 rtl/mem_loader.sv | 194 +++++++++++++++++++
 tb/tb_mem_loader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_loader_pkg.sv
// Shared definitions for the byte-stream memory loader: header codes,
// FSM state encoding and default limits.
package mem_loader_pkg;

  localparam logic [7:0] HDR_IRAM = 8'h01;
  localparam logic [7:0] HDR_DRAM = 8'h02;
  localparam logic [7:0] HDR_RUN  = 8'h03;

  localparam int MAX_WORDS_DEF = 511;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_GAP,
    ST_RUN
  } state_e;

  // Width of a down-counter able to hold the larger of two load values.
  function automatic int tmr_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte stream from the serial receiver into the loader (valid/ready).
interface mem_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/loader_pulse_timer.sv
// Loadable down-counter; expire_o flags the last cycle of a loaded interval.
module loader_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A load of N gives N cycles; expiry is the terminal count of one.
  assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/mem_loader.sv
// Frame-driven loader: parses header/count/words from a byte stream and writes
// them into IRAM or DRAM with timed strobes, or enables the processor.
//
// state      | meaning
// ST_IDLE    | waiting for a header byte
// ST_CNT_HI  | waiting for word count high byte
// ST_CNT_LO  | waiting for word count low byte; count checked here
// ST_DATA_HI | waiting for high byte of next word
// ST_DATA_LO | waiting for low byte; word latched on accept
// ST_WRITE   | one setup cycle, then strobe high for WR_CYCLES
// ST_GAP     | strobe low, address/data held for GAP_CYCLES
// ST_RUN     | processor running, still listening for headers
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int WR_CYCLES  = 4,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_WORDS  = MAX_WORDS_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  mem_loader_if.slave   rx,
  output logic [8:0]    addr_ext,
  output logic [15:0]   mem_data,
  output logic          iram_write_ext,
  output logic          dram_write_ext,
  output logic          start_2,
  output logic          start_3,
  output logic          start,
  output logic          done,
  output logic          err
);

  localparam int GAP_LOAD = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int TMR_W    = tmr_width(WR_CYCLES + 1, GAP_LOAD);
  localparam logic [TMR_W-1:0] WR_VAL  = TMR_W'(WR_CYCLES + 1);
  localparam logic [TMR_W-1:0] GAP_VAL = TMR_W'(GAP_LOAD);

  state_e      st_q;
  logic        rdy_q;
  logic [8:0]  addr_q;
  logic [15:0] data_q;
  logic [7:0]  byte_hi_q;
  logic [7:0]  cnt_hi_q;
  logic [15:0] words_q;
  logic        iram_wr_q;
  logic        dram_wr_q;
  logic        start2_q;
  logic        start3_q;
  logic        start_q;
  logic        done_q;
  logic        err_q;

  logic        acc;
  logic [15:0] cnt_d;
  logic        tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic        tmr_exp;

  assign acc   = rx.rx_valid & rdy_q;
  assign cnt_d = {cnt_hi_q, rx.rx_data};

  assign tmr_load = ((st_q == ST_DATA_LO) && acc) || ((st_q == ST_WRITE) && tmr_exp);
  assign tmr_val  = (st_q == ST_WRITE) ? GAP_VAL : WR_VAL;

  loader_pulse_timer #(.W(TMR_W)) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_exp)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q      <= ST_IDLE;
      rdy_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      byte_hi_q <= '0;
      cnt_hi_q  <= '0;
      words_q   <= '0;
      iram_wr_q <= 1'b0;
      dram_wr_q <= 1'b0;
      start2_q  <= 1'b0;
      start3_q  <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      rdy_q  <= 1'b1;
      case (st_q)
        ST_IDLE, ST_RUN: begin
          if (acc) begin
            case (rx.rx_data)
              HDR_IRAM, HDR_DRAM: begin
                st_q     <= ST_CNT_HI;
                addr_q   <= 9'd1;
                start_q  <= 1'b0;
                start2_q <= (rx.rx_data == HDR_IRAM);
                start3_q <= (rx.rx_data == HDR_DRAM);
              end
              HDR_RUN: begin
                st_q    <= ST_RUN;
                start_q <= 1'b1;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        ST_CNT_HI: begin
          if (acc) begin
            cnt_hi_q <= rx.rx_data;
            st_q     <= ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (acc) begin
            if (cnt_d == 16'd0) begin
              st_q     <= ST_IDLE;
              done_q   <= 1'b1;
              start2_q <= 1'b0;
              start3_q <= 1'b0;
            end else if (cnt_d > 16'(MAX_WORDS)) begin
              st_q     <= ST_IDLE;
              err_q    <= 1'b1;
              start2_q <= 1'b0;
              start3_q <= 1'b0;
            end else begin
              words_q <= cnt_d;
              st_q    <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (acc) begin
            byte_hi_q <= rx.rx_data;
            st_q      <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (acc) begin
            data_q <= {byte_hi_q, rx.rx_data};
            st_q   <= ST_WRITE;
            rdy_q  <= 1'b0;
          end
        end
        ST_WRITE: begin
          rdy_q <= 1'b0;
          if (tmr_exp) begin
            iram_wr_q <= 1'b0;
            dram_wr_q <= 1'b0;
            st_q      <= ST_GAP;
          end else begin
            // First WRITE cycle leaves data settled before the strobe rises.
            iram_wr_q <= start2_q;
            dram_wr_q <= start3_q;
          end
        end
        ST_GAP: begin
          if (tmr_exp) begin
            addr_q  <= addr_q + 9'd1;
            words_q <= words_q - 16'd1;
            if (words_q == 16'd1) begin
              st_q     <= ST_IDLE;
              done_q   <= 1'b1;
              start2_q <= 1'b0;
              start3_q <= 1'b0;
            end else begin
              st_q <= ST_DATA_HI;
            end
          end else begin
            rdy_q <= 1'b0;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign rx.rx_ready    = rdy_q;
  assign addr_ext       = addr_q;
  assign mem_data       = data_q;
  assign iram_write_ext = iram_wr_q;
  assign dram_write_ext = dram_wr_q;
  assign start_2        = start2_q;
  assign start_3        = start3_q;
  assign start          = start_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes queued as frames are sent,
// popped when a strobe rises.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int WR = 4;

  typedef struct packed {
    logic        dram;
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clock;
  logic        reset_n;
  logic [8:0]  addr_ext;
  logic [15:0] mem_data;
  logic        iram_write_ext, dram_write_ext;
  logic        start_2, start_3, start, done, err;

  mem_loader_if ifc ();

  mem_loader #(.WR_CYCLES(WR), .GAP_CYCLES(4), .MAX_WORDS(511)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rx             (ifc.slave),
    .addr_ext       (addr_ext),
    .mem_data       (mem_data),
    .iram_write_ext (iram_write_ext),
    .dram_write_ext (dram_write_ext),
    .start_2        (start_2),
    .start_3        (start_3),
    .start          (start),
    .done           (done),
    .err            (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int  n_chk = 0;
  int  n_pass = 0;
  wr_t sb[$];
  int  done_cnt = 0, err_cnt = 0, full_wr = 0;
  int  stb_len = 0;
  logic stb_prev = 1'b0;
  logic [8:0]  prev_addr = '0, lat_addr = '0;
  logic [15:0] prev_data = '0, lat_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Strobe monitor: order/content via scoreboard, length, hold and exclusivity.
  always @(negedge clock) begin
    logic stb;
    wr_t  e;
    if (!reset_n) begin
      stb_prev  = 1'b0;
      stb_len   = 0;
      prev_addr = '0;
      prev_data = '0;
    end else begin
      stb = iram_write_ext | dram_write_ext;
      if (iram_write_ext && dram_write_ext)
        chk("strobe_excl", {iram_write_ext, dram_write_ext}, 32'h1);
      if (done) begin
        done_cnt++;
        chk("done_mode", {start_2, start_3}, 32'h0);
      end
      if (err) err_cnt++;
      if (stb && !stb_prev) begin
        chk("pre_stable", {prev_addr, prev_data}, {addr_ext, mem_data});
        chk("rdy_in_write", ifc.rx_ready, 32'h0);
        if (sb.size() == 0) begin
          chk("unexp_write", {addr_ext, mem_data}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("wr_sel", {iram_write_ext, dram_write_ext}, e.dram ? 32'h1 : 32'h2);
          chk("wr_mode", {start_2, start_3}, e.dram ? 32'h1 : 32'h2);
          chk("wr_addr", addr_ext, e.addr);
          chk("wr_data", mem_data, e.data);
        end
        lat_addr = addr_ext;
        lat_data = mem_data;
      end
      if (stb) stb_len++;
      if (!stb && stb_prev) begin
        chk("stb_len", stb_len, WR);
        chk("hold", {addr_ext, mem_data}, {lat_addr, lat_data});
        full_wr++;
        stb_len = 0;
      end
      stb_prev  = stb;
      prev_addr = addr_ext;
      prev_data = mem_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clock);
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    while (!ifc.rx_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("send_rdy", ifc.rx_ready, 32'h1);
    @(posedge clock);
    #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic dram, input logic [8:0] a, input logic [15:0] d);
    sb.push_back('{dram: dram, addr: a, data: d});
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic settle_and_check(input string tag, input int exp_done, input int exp_err,
                                  input int d0, input int e0);
    repeat (15) @(negedge clock);
    chk({tag, "_sb_empty"}, sb.size(), 32'h0);
    chk({tag, "_done"}, done_cnt - d0, exp_done);
    chk({tag, "_err"}, err_cnt - e0, exp_err);
  endtask

  initial begin
    int d0, e0, w0, t;
    reset_n      = 1'b0;
    ifc.rx_valid = 1'b0;
    ifc.rx_data  = 8'h00;
    #23;
    chk("rst_outs", {ifc.rx_ready, addr_ext, mem_data, iram_write_ext, dram_write_ext,
                     start_2, start_3, start, done, err}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    chk("rdy_pre_edge", ifc.rx_ready, 32'h0);
    @(posedge clock);
    #1;
    chk("rdy_after_rst", ifc.rx_ready, 32'h1);

    // Two-word IRAM load
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h01);
    chk("hdr_iram_mode", {start, start_2, start_3}, 32'h2);
    chk("hdr_addr", addr_ext, 32'h1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(1'b0, 9'd1, 16'h1234);
    send_word(1'b0, 9'd2, 16'hABCD);
    settle_and_check("iram2", 1, 0, d0, e0);
    chk("iram2_mode_off", {start_2, start_3}, 32'h0);

    // One-word DRAM load
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h02);
    chk("hdr_dram_mode", {start_2, start_3}, 32'h1);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(1'b1, 9'd1, 16'h0005);
    settle_and_check("dram1", 1, 0, d0, e0);
    chk("dram1_mode_off", start_3, 32'h0);

    // Count above MAX_WORDS
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h02);
    send_byte(8'h02);
    send_byte(8'h00);
    settle_and_check("cnt_big", 0, 1, d0, e0);
    chk("cnt_big_rdy", ifc.rx_ready, 32'h1);

    // Unknown header then empty load
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h7F);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    settle_and_check("bad_hdr_zero", 1, 1, d0, e0);

    // RUN then a new load header
    send_byte(8'h03);
    repeat (20) @(negedge clock);
    chk("run_start", start, 32'h1);
    send_byte(8'h01);
    chk("run_to_load", {start, start_2}, 32'h1);
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h00);
    send_byte(8'h00);
    settle_and_check("run_reload", 1, 0, d0, e0);

    // Reset during the second strobe of a three-word load
    w0 = full_wr;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(1'b0, 9'd1, 16'h1111);
    send_word(1'b0, 9'd2, 16'h2222);
    t = 0;
    while (!iram_write_ext && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("mid_stb_seen", iram_write_ext, 32'h1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_outs", {ifc.rx_ready, addr_ext, mem_data, iram_write_ext, dram_write_ext,
                         start_2, start_3, start, done, err}, 32'h0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("mid_full_writes", full_wr - w0, 32'h1);
    chk("mid_sb_empty", sb.size(), 32'h0);
    chk("mid_rdy", ifc.rx_ready, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish, got running want finished");
    $fatal(1);
  end

endmodule
